// File: rtl/loopback_pkg.sv
// ============================================================================
// Module      : loopback_pkg
// Description : Shared constants, baud-divider helper and FSM state types for
//               the serial loopback. Line levels selected by SERIAL_INVERT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loopback_pkg;

    localparam int c_CLK_FREQ_HZ = 100_000_000;
    localparam int c_BAUD_RATE   = 9600;
    localparam int c_CNT_W       = 14;

`ifdef SERIAL_INVERT_EN
    // Board level path inverts the line: idle/stop low, start high.
    localparam logic c_IDLE_LVL  = 1'b0;
    localparam logic c_START_LVL = 1'b1;
`else
    localparam logic c_IDLE_LVL  = 1'b1;
    localparam logic c_START_LVL = 1'b0;
`endif

    // Cycles per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 2-flop input synchronizer; pulses
//               o_valid for one cycle per good frame (SERIAL_INVERT_EN levels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import loopback_pkg::*;
#(
    parameter int BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(BAUD_DIV / 2 - 1);

    logic               r_sync1;
    logic               r_sync2;
    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_shift_en;
    logic               w_stop_ok;
    logic               r_valid;
    logic [7:0]         r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= c_IDLE_LVL;
            r_sync2 <= c_IDLE_LVL;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_shift_en  = 1'b0;
        w_stop_ok   = 1'b0;
        case (r_state)
            R_IDLE: begin
                w_cnt_nxt = '0;
                if (r_sync2 == c_START_LVL) w_state_nxt = R_START;
            end
            R_START: begin
                // Mid-start resample rejects glitches shorter than half a bit.
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_sync2 == c_IDLE_LVL) ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_stop_ok   = (r_sync2 == c_IDLE_LVL);
                    w_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_valid <= w_stop_ok;
            if (r_state == R_START) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_stop_ok) r_data <= r_shift;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/loopback_top.sv
// ============================================================================
// Module      : loopback_top
// Description : Serial loopback: UART RX -> one-byte holding register -> UART
//               TX. Line polarity selected by SERIAL_INVERT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loopback_top
    import loopback_pkg::*;
#(
    parameter int CLK_FREQ_HZ = c_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = c_BAUD_RATE
) (
    input  logic USER_CLK,
    input  logic FPGA_CPU_RESET,
    input  logic FPGA_SERIAL_RX,
    output logic FPGA_SERIAL_TX
);

    localparam int                 c_BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(c_BAUD_DIV - 1);

    logic clk;
    logic rst;
    assign clk = USER_CLK;
    assign rst = FPGA_CPU_RESET;

    logic               w_rx_valid;
    logic [7:0]         w_rx_data;
    logic [7:0]         r_hold;
    logic               r_full;
    tx_state_t          r_tx_state;
    tx_state_t          w_tx_state_nxt;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic [c_CNT_W-1:0] w_tx_cnt_nxt;
    logic [2:0]         r_tx_bit_idx;
    logic [7:0]         r_tx_shift;
    logic               w_accept;
    logic               w_shift_en;
    logic               w_tx_lvl;
    logic               r_tx;

    uart_rx #(
        .BAUD_DIV (c_BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (FPGA_SERIAL_RX),
        .o_valid (w_rx_valid),
        .o_data  (w_rx_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + c_CNT_W'(1);
        w_accept       = 1'b0;
        w_shift_en     = 1'b0;
        w_tx_lvl       = c_IDLE_LVL;
        case (r_tx_state)
            T_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (r_full) begin
                    w_accept       = 1'b1;
                    w_tx_state_nxt = T_START;
                end
            end
            T_START: begin
                w_tx_lvl = c_START_LVL;
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = T_DATA;
                end
            end
            T_DATA: begin
                w_tx_lvl = r_tx_shift[0];
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    w_shift_en   = 1'b1;
                    if (r_tx_bit_idx == 3'd7) w_tx_state_nxt = T_STOP;
                end
            end
            T_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = T_IDLE;
                end
            end
            default: begin
                w_tx_cnt_nxt   = '0;
                w_tx_state_nxt = T_IDLE;
            end
        endcase
    end

    // A byte arriving while the register is still full is dropped; a byte
    // arriving in the very cycle the TX takes the held one still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_rx_valid && (!r_full || w_accept)) begin
            r_hold <= w_rx_data;
            r_full <= 1'b1;
        end else if (w_accept) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift   <= '0;
            r_tx_bit_idx <= '0;
            r_tx         <= c_IDLE_LVL;
        end else begin
            r_tx <= w_tx_lvl;
            if (w_accept) begin
                r_tx_shift   <= r_hold;
                r_tx_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit_idx <= r_tx_bit_idx + 3'd1;
            end
        end
    end

    assign FPGA_SERIAL_TX = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_loopback_top.sv
// ============================================================================
// Module      : tb_loopback_top
// Description : Self-checking bench for loopback_top; line levels follow
//               SERIAL_INVERT_EN. Scaled clock/baud give 17 cycles per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loopback_top;

    localparam int c_CLK_HZ = 1_000_000;
    localparam int c_BAUD   = 60_000;
    localparam int c_DIV    = 17;   // round(1e6 / 60e3)

`ifdef SERIAL_INVERT_EN
    localparam logic c_IDLE    = 1'b0;
    localparam logic c_START   = 1'b1;
    localparam int   c_RST_BIT = 5;   // data bit of 0x61 that differs from idle
`else
    localparam logic c_IDLE    = 1'b1;
    localparam logic c_START   = 1'b0;
    localparam int   c_RST_BIT = 3;
`endif

    logic clk;
    logic rst;
    logic r_rx;
    logic w_tx;

    int n_tests;
    int n_fail;
    int n_frames;

    logic [7:0] exp_q[$];

    logic       mon_active;
    logic       mon_chk;
    logic [9:0] mon_pat;
    int         mon_idx;
    int         mon_match;

    loopback_top #(
        .CLK_FREQ_HZ (c_CLK_HZ),
        .BAUD_RATE   (c_BAUD)
    ) dut (
        .USER_CLK       (clk),
        .FPGA_CPU_RESET (rst),
        .FPGA_SERIAL_RX (r_rx),
        .FPGA_SERIAL_TX (w_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic lvl);
        r_rx = lvl;
        repeat (c_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        drive_bit(c_START);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_lvl);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 * c_DIV; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !mon_active) break;
        end
        chk(tag, {23'd0, mon_active, 8'(exp_q.size())}, 32'd0);
    endtask

    // Frame monitor: every sample of every bit must match the expected frame.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && w_tx === c_START) begin
                n_frames++;
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_match  = 0;
                if (exp_q.size() == 0) begin
                    mon_chk = 1'b0;
                    chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_chk = 1'b1;
                    mon_pat = {c_IDLE, exp_q.pop_front(), c_START};
                end
            end
            if (mon_active) begin
                if (w_tx === mon_pat[mon_idx / c_DIV]) mon_match++;
                if (mon_chk && (mon_idx % c_DIV == c_DIV - 1)) begin
                    chk($sformatf("frame%0d_bit%0d", n_frames, mon_idx / c_DIV),
                        32'(mon_match), 32'(c_DIV));
                end
                if (mon_idx % c_DIV == c_DIV - 1) mon_match = 0;
                mon_idx++;
                if (mon_idx == 10 * c_DIV) mon_active = 1'b0;
            end
        end
    end

    initial begin
        int f0;
        int busy;
        int target;
        logic found;

        n_tests    = 0;
        n_fail     = 0;
        n_frames   = 0;
        mon_active = 1'b0;
        mon_chk    = 1'b0;
        mon_pat    = '0;
        mon_idx    = 0;
        mon_match  = 0;
        r_rx       = c_IDLE;
        rst        = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, w_tx}, {31'd0, c_IDLE});
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_reset", {31'd0, w_tx}, {31'd0, c_IDLE});

        // Single byte 'a'
        exp_q.push_back(8'h61);
        send_byte(8'h61, c_IDLE);
        wait_drain("drain_a");

        // Back-to-back stream
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h3C);
        send_byte(8'hAA, c_IDLE);
        send_byte(8'h55, c_IDLE);
        send_byte(8'h3C, c_IDLE);
        wait_drain("drain_stream");

        // Short glitch to start level: no frame
        f0   = n_frames;
        busy = 0;
        r_rx = c_START;
        repeat (4) @(posedge clk);
        #1;
        r_rx = c_IDLE;
        for (int i = 0; i < 20 * c_DIV; i++) begin
            @(negedge clk);
            if (w_tx !== c_IDLE) busy++;
        end
        chk("glitch_tx_active_cycles", 32'(busy), 32'd0);
        chk("glitch_frames", 32'(n_frames), 32'(f0));

        // Framing error: stop bit at start level, byte discarded
        f0 = n_frames;
        send_byte(8'h61, c_START);
        drive_bit(c_IDLE);
        drive_bit(c_IDLE);
        repeat (15 * c_DIV) @(negedge clk);
        chk("framing_frames", 32'(n_frames), 32'(f0));

        // Reset in the middle of the TX data bits
        exp_q.push_back(8'h61);
        send_byte(8'h61, c_IDLE);
        target = (c_RST_BIT + 1) * c_DIV + c_DIV / 2;
        found  = 1'b0;
        for (int i = 0; i < 20 * c_DIV; i++) begin
            @(negedge clk);
            #1;
            if (mon_active && mon_idx == target) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reach_data_bit", {31'd0, found}, 32'd1);
        chk("pre_rst_tx", {31'd0, w_tx}, {31'd0, ~c_IDLE});
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, w_tx}, {31'd0, c_IDLE});
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Echo after reset
        exp_q.push_back(8'h61);
        send_byte(8'h61, c_IDLE);
        wait_drain("drain_after_reset");
        chk("frames_total", 32'(n_frames), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
